// File: rtl/array_pkg.sv
// Shared sizing and FSM state for the array-summing datapath (streamer and accumulator).
package array_pkg;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 5;
  localparam int IDX_W  = 9;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;
endpackage

// File: rtl/array_regfile.sv
// DEPTH x DATA_W register array: one write port, one combinational read port, async clear.
module array_regfile #(
  parameter int DATA_W = array_pkg::DATA_W,
  parameter int DEPTH  = array_pkg::DEPTH,
  parameter int IDX_W  = array_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);
  logic [DEPTH-1:0][DATA_W-1:0] r_mem;

  // Out-of-range write addresses simply match no entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (i_wr_en && i_wr_addr == IDX_W'(i)) r_mem[i] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (i_rd_addr == IDX_W'(i)) o_rd_data = r_mem[i];
  end
endmodule

// File: rtl/array_streamer.sv
// Streams the first min(len, DEPTH) array words out one per cycle on a valid/ready
// handshake after a rising edge of start; flags the last beat and pulses done.
module array_streamer
  import array_pkg::*;
#(
  parameter int DATA_W = array_pkg::DATA_W,
  parameter int DEPTH  = array_pkg::DEPTH,
  parameter int IDX_W  = array_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [IDX_W-1:0]  len,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  index,
  output logic              valid,
  output logic              last,
  output logic              busy,
  output logic              done
);
  state_e             r_state, w_nxt_state;
  logic               r_start_q;
  logic [IDX_W-1:0]   r_len, w_nxt_len;
  logic [IDX_W-1:0]   r_index, w_nxt_index;
  logic [DATA_W-1:0]  r_data, w_nxt_data;
  logic               r_valid, w_nxt_valid;
  logic               r_last, w_nxt_last;
  logic               w_trig;
  logic [IDX_W-1:0]   w_len_eff;
  logic [IDX_W-1:0]   w_rd_addr;
  logic [DATA_W-1:0]  w_rd_data;

  assign w_trig    = start & ~r_start_q;
  assign w_len_eff = (len > IDX_W'(DEPTH)) ? IDX_W'(DEPTH) : len;
  // In IDLE the read port pre-fetches element 0; while streaming it looks one ahead.
  assign w_rd_addr = (r_state == IDLE) ? '0 : r_index + IDX_W'(1);

  array_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_start_q <= 1'b0;
      r_len     <= '0;
      r_index   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_start_q <= start;
      r_len     <= w_nxt_len;
      r_index   <= w_nxt_index;
      r_data    <= w_nxt_data;
      r_valid   <= w_nxt_valid;
      r_last    <= w_nxt_last;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_len   = r_len;
    w_nxt_index = r_index;
    w_nxt_data  = r_data;
    w_nxt_valid = r_valid;
    w_nxt_last  = r_last;
    case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_nxt_len = w_len_eff;
          if (w_len_eff == '0) begin
            w_nxt_state = DONE;
          end else begin
            w_nxt_state = STREAM;
            w_nxt_index = '0;
            w_nxt_data  = w_rd_data;
            w_nxt_valid = 1'b1;
            w_nxt_last  = (w_len_eff == IDX_W'(1));
          end
        end
      end
      STREAM: begin
        if (r_valid && ready) begin
          if (r_last) begin
            w_nxt_valid = 1'b0;
            w_nxt_last  = 1'b0;
            w_nxt_state = DONE;
          end else begin
            w_nxt_index = r_index + IDX_W'(1);
            w_nxt_data  = w_rd_data;
            w_nxt_last  = (r_index + IDX_W'(2) == r_len);
          end
        end
      end
      DONE:    w_nxt_state = IDLE;
      default: w_nxt_state = IDLE;
    endcase
  end

  assign data  = r_data;
  assign index = r_index;
  assign valid = r_valid;
  assign last  = r_last;
  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);
endmodule

// File: tb/tb_array_streamer.sv
// Bench for array_streamer: directed scenarios plus randomized runs against a
// transaction-level model (array snapshot at trigger, patched by writes to unloaded beats).
module tb_array_streamer;
  localparam int DW = 32;
  localparam int DP = 5;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [IW-1:0] len = '0;
  logic          ready = 1'b0;
  logic [DW-1:0] data;
  logic [IW-1:0] index;
  logic          valid, last, busy, done;

  int            n_chk = 0;
  int            n_err = 0;
  logic [DW-1:0] mem_m [DP];
  logic [DW-1:0] got_d [8];
  int            got_n;
  longint        got_sum;
  int            nv, nd;

  array_streamer dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .len(len), .ready(ready), .data(data), .index(index),
    .valid(valid), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = IW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < DP) mem_m[a] = d;
  endtask

  // rmode 0: ready=1, 1: ready=pat[cyc%8], 2: random ready and random writes.
  task automatic run_stream(input int len_in, input int rmode, input logic [7:0] pat,
                            input int wr_cyc, input int wr_a, input logic [DW-1:0] wr_d);
    int L, nb, stalls, a;
    logic [DW-1:0] exp [DP];
    logic [DW-1:0] pd;
    logic [IW-1:0] pi;
    bit pstall, fin;
    L = (len_in > DP) ? DP : len_in;
    for (int i = 0; i < DP; i++) exp[i] = mem_m[i];
    got_n = 0; got_sum = 0;
    len = IW'(len_in); start = 1'b1;
    tick();
    start = 1'b0;
    chk("trig_busy", 64'(busy), 64'(1));
    chk("trig_valid", 64'(valid), 64'(L > 0));
    if (L == 0) chk("l0_done", 64'(done), 64'(1));
    nb = 0; stalls = 0; pstall = 1'b0; fin = (L == 0); pd = '0; pi = '0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (done) begin
        fin = 1'b1;
        chk("beats", 64'(nb), 64'(L));
        chk("done_time", 64'(cyc), 64'(L + stalls));
        chk("done_nvalid", 64'(valid), 64'(0));
      end else begin
        chk("str_valid", 64'(valid), 64'(1));
        if (pstall) begin
          chk("stall_data", 64'(data), 64'(pd));
          chk("stall_idx", 64'(index), 64'(pi));
        end
        case (rmode)
          0:       ready = 1'b1;
          1:       ready = pat[cyc % 8];
          default: ready = 1'($urandom_range(0, 1));
        endcase
        if (rmode == 2 && $urandom_range(0, 2) == 0) begin
          wr_en = 1'b1; wr_addr = IW'($urandom_range(0, 7)); wr_data = $urandom;
        end else if (cyc == wr_cyc) begin
          wr_en = 1'b1; wr_addr = IW'(wr_a); wr_data = wr_d;
        end
        if (valid && ready) begin
          if (nb < L) begin
            chk("beat_data", 64'(data), 64'(exp[nb]));
            chk("beat_idx", 64'(index), 64'(nb));
            chk("beat_last", 64'(last), 64'(nb == L - 1));
            got_d[nb] = data;
            got_sum += longint'(data);
          end else begin
            chk("extra_beat", 64'(nb), 64'(L));
          end
          nb++;
          got_n = nb;
        end else begin
          stalls++;
        end
        pstall = valid && !ready; pd = data; pi = index;
        // A write reaches the stream only if its beat is loaded after this edge.
        a = int'(wr_addr);
        if (wr_en && a < DP) begin
          mem_m[a] = wr_data;
          if (a > nb && a < L) exp[a] = wr_data;
        end
        tick();
        wr_en = 1'b0;
      end
    end
    if (!fin) chk("done_timeout", 64'(0), 64'(1));
    tick();
    chk("done_1cyc", 64'(done), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DP; i++) mem_m[i] = '0;
    repeat (3) tick();
    chk("rst_outs", 64'({data, index, valid, last, busy, done}), 64'(0));
    reset_n = 1'b1;
    tick();

    // Full stream, ready held high.
    for (int i = 0; i < DP; i++) wr(i, DW'(10 * (i + 1)));
    run_stream(5, 0, 8'hFF, -1, 0, '0);
    for (int i = 0; i < 5; i++) chk("full_beat", 64'(got_d[i]), 64'(10 * (i + 1)));
    chk("full_sum", 64'(got_sum), 64'(150));

    // Backpressure pattern 1,0,0,1,1,0,1.
    run_stream(3, 1, 8'b1101_1001, -1, 0, '0);
    chk("bp_count", 64'(got_n), 64'(3));
    chk("bp_beat2", 64'(got_d[2]), 64'(30));

    // Length boundaries.
    run_stream(0, 0, 8'hFF, -1, 0, '0);
    chk("l0_beats", 64'(got_n), 64'(0));
    run_stream(9, 0, 8'hFF, -1, 0, '0);
    chk("l9_beats", 64'(got_n), 64'(5));

    // Start held high across completion: exactly one run.
    len = 2; ready = 1'b1; start = 1'b1; nv = 0; nd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid && ready) nv++;
      if (done) nd++;
    end
    chk("hold_beats", 64'(nv), 64'(2));
    chk("hold_dones", 64'(nd), 64'(1));
    chk("hold_busy", 64'(busy), 64'(0));
    start = 1'b0; ready = 1'b0;
    tick();

    // Start re-pulsed mid-stream is ignored.
    len = 3; start = 1'b1; tick(); start = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("mid_busy", 64'(busy), 64'(1));
    chk("mid_idx", 64'(index), 64'(0));
    ready = 1'b1; nv = 0; nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid && ready) nv++;
      tick();
      if (done) nd++;
    end
    chk("mid_beats", 64'(nv), 64'(3));
    chk("mid_dones", 64'(nd), 64'(1));
    ready = 1'b0;

    // Write to a not-yet-loaded element during a stall, then an out-of-range write.
    run_stream(5, 1, 8'b1111_1101, 1, 3, DW'(99));
    chk("late_wr", 64'(got_d[3]), 64'(99));
    wr(7, DW'(123));
    run_stream(5, 0, 8'hFF, -1, 0, '0);
    chk("oor_wr3", 64'(got_d[3]), 64'(99));
    chk("oor_wr4", 64'(got_d[4]), 64'(50));

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 2; k++) wr(int'($urandom_range(0, 7)), $urandom);
      run_stream(int'($urandom_range(0, 9)), 2, 8'hFF, -1, 0, '0);
    end

    // Asynchronous reset at the third beat.
    len = 5; ready = 1'b1; start = 1'b1; tick(); start = 1'b0; tick(); tick();
    chk("pre_rst_idx", 64'(index), 64'(2));
    #2 reset_n = 1'b0;
    #1 chk("async_rst", 64'({data, index, valid, last, busy, done}), 64'(0));
    ready = 1'b0;
    for (int i = 0; i < DP; i++) mem_m[i] = '0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
    chk("post_rst_done", 64'(done), 64'(0));
    run_stream(2, 0, 8'hFF, -1, 0, '0);
    chk("clr_beat0", 64'(got_d[0]), 64'(0));
    chk("clr_beat1", 64'(got_d[1]), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
